// File: rtl/draw_point_receiver.sv
// DrawPoint slave: buffers point strobes in a FIFO and writes them to the
// framebuffer over Avalon-MM, one single-beat write per point.
// Ports:
//   csi_dps_clock_clk / rsi_dps_reset_n  clock, async active-low reset
//   coe_dps_ul1Update, ul9PosX, ul9PosY, ul12Rgb12Data  point input
//   avm_fb_*  framebuffer master (address, write, writedata, waitrequest)
//   coe_dps_ul1Overflow  sticky FIFO-full point loss
//   coe_dps_ul1Busy  FIFO non-empty or write pending
//   coe_dps_ul16DropCount  drop counter, only with DRAW_POINT_RECEIVER_STATS_EN
module draw_point_receiver #(
    parameter int HRES       = 320,
    parameter int VRES       = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 17
) (
    input  logic              csi_dps_clock_clk,
    input  logic              rsi_dps_reset_n,
    input  logic              coe_dps_ul1Update,
    input  logic [8:0]        coe_dps_ul9PosX,
    input  logic [8:0]        coe_dps_ul9PosY,
    input  logic [11:0]       coe_dps_ul12Rgb12Data,
    output logic [ADDR_W-1:0] avm_fb_address,
    output logic              avm_fb_write,
    output logic [15:0]       avm_fb_writedata,
    input  logic              avm_fb_waitrequest,
`ifdef DRAW_POINT_RECEIVER_STATS_EN
    output logic [15:0]       coe_dps_ul16DropCount,
`endif
    output logic              coe_dps_ul1Overflow,
    output logic              coe_dps_ul1Busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [9:0] HRES_C = 10'(HRES);
    localparam logic [9:0] VRES_C = 10'(VRES);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t           state;
    logic [29:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             inRange;
    logic             full;
    logic             push;
    logic             pop;
    logic [8:0]       headX;
    logic [8:0]       headY;
    logic [11:0]      headRgb;

    assign inRange = ({1'b0, coe_dps_ul9PosX} < HRES_C)
                  && ({1'b0, coe_dps_ul9PosY} < VRES_C);
    // Fullness uses the start-of-cycle count, so a same-cycle pop
    // never makes room for the incoming point.
    assign full = (count == DEPTH_C);
    assign push = coe_dps_ul1Update && inRange && !full;
    assign pop  = (state == IDLE) && (count != '0);
    assign {headX, headY, headRgb} = fifoMem[rdPtr];

    assign coe_dps_ul1Busy = (state != IDLE) || (count != '0);

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge csi_dps_clock_clk) begin
        if (push) begin
            fifoMem[wrPtr] <= {coe_dps_ul9PosX, coe_dps_ul9PosY,
                               coe_dps_ul12Rgb12Data};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge csi_dps_clock_clk or negedge rsi_dps_reset_n) begin
        if (!rsi_dps_reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge csi_dps_clock_clk or negedge rsi_dps_reset_n) begin
        if (!rsi_dps_reset_n) begin
            coe_dps_ul1Overflow <= 1'b0;
        end else if (coe_dps_ul1Update && inRange && full) begin
            coe_dps_ul1Overflow <= 1'b1;
        end
    end

    always_ff @(posedge csi_dps_clock_clk or negedge rsi_dps_reset_n) begin
        if (!rsi_dps_reset_n) begin
            state            <= IDLE;
            avm_fb_write     <= 1'b0;
            avm_fb_address   <= '0;
            avm_fb_writedata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        avm_fb_address   <= ADDR_W'(headY) * ADDR_W'(HRES)
                                          + ADDR_W'(headX);
                        avm_fb_writedata <= {4'h0, headRgb};
                        avm_fb_write     <= 1'b1;
                        state            <= WRITE;
                    end
                end
                WRITE: begin
                    if (!avm_fb_waitrequest) begin
                        avm_fb_write <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    avm_fb_write <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef DRAW_POINT_RECEIVER_STATS_EN
    logic drop;

    // A point that is both out of range and hits a full FIFO counts once.
    assign drop = coe_dps_ul1Update && (!inRange || full);

    always_ff @(posedge csi_dps_clock_clk or negedge rsi_dps_reset_n) begin
        if (!rsi_dps_reset_n) begin
            coe_dps_ul16DropCount <= '0;
        end else if (drop && (coe_dps_ul16DropCount != 16'hFFFF)) begin
            coe_dps_ul16DropCount <= coe_dps_ul16DropCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_draw_point_receiver.sv
// Scoreboard bench for draw_point_receiver: stimulus queues expected writes,
// a negedge monitor compares every cycle the DUT asserts avm_fb_write.
module tb_draw_point_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        update;
    logic [8:0]  posX;
    logic [8:0]  posY;
    logic [11:0] rgb;
    logic [16:0] address;
    logic        write;
    logic [15:0] wdata;
    logic        waitreq;
    logic        overflow;
    logic        busy;
`ifdef DRAW_POINT_RECEIVER_STATS_EN
    logic [15:0] dropCount;
`endif

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   accepted = 0;
    int   highCycles = 0;
    int   a0;
    int   h0;

    always #5 clk = ~clk;

    draw_point_receiver dut (
        .csi_dps_clock_clk     (clk),
        .rsi_dps_reset_n       (rst_n),
        .coe_dps_ul1Update     (update),
        .coe_dps_ul9PosX       (posX),
        .coe_dps_ul9PosY       (posY),
        .coe_dps_ul12Rgb12Data (rgb),
        .avm_fb_address        (address),
        .avm_fb_write          (write),
        .avm_fb_writedata      (wdata),
        .avm_fb_waitrequest    (waitreq),
`ifdef DRAW_POINT_RECEIVER_STATS_EN
        .coe_dps_ul16DropCount (dropCount),
`endif
        .coe_dps_ul1Overflow   (overflow),
        .coe_dps_ul1Busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendPoint(input logic [8:0] x, input logic [8:0] y,
                             input logic [11:0] c);
        posX   = x;
        posY   = y;
        rgb    = c;
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    // Monitor: every write-high cycle must match the queue head; the
    // entry retires only on the cycle the slave accepts it.
    always @(negedge clk) begin
        if (rst_n && write) begin
            highCycles++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%0h required=none",
                         address, wdata);
            end else begin
                check("wr_addr", 32'(address), 32'(sb[0].addr));
                check("wr_data", 32'(wdata), 32'(sb[0].data));
                if (!waitreq) begin
                    void'(sb.pop_front());
                    accepted++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        update  = 1'b0;
        posX    = '0;
        posY    = '0;
        rgb     = '0;
        waitreq = 1'b0;
        #3;
        check("rst_write", 32'(write), 0);
        check("rst_addr", 32'(address), 0);
        check("rst_data", 32'(wdata), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 100 cycles
        h0 = highCycles;
        repeat (100) tick();
        check("idle_writes", 32'(highCycles - h0), 0);
        check("idle_ovf", 32'(overflow), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_addr", 32'(address), 0);

        // Single point, 5 + 2*320 = 645
        sb.push_back('{addr: 17'd645, data: 16'h0ABC});
        sendPoint(9'd5, 9'd2, 12'hABC);
        @(negedge clk);
        check("lat_c1_write", 32'(write), 0);
        check("lat_c1_busy", 32'(busy), 1);
        @(negedge clk);
        check("lat_c2_write", 32'(write), 1);
        @(negedge clk);
        check("lat_c3_write", 32'(write), 0);
        check("lat_c3_busy", 32'(busy), 0);
        repeat (5) tick();

        // Same point, waitrequest high for 3 edges
        a0 = accepted;
        h0 = highCycles;
        waitreq = 1'b1;
        sb.push_back('{addr: 17'd645, data: 16'h0ABC});
        sendPoint(9'd5, 9'd2, 12'hABC);
        repeat (4) tick();
        waitreq = 1'b0;
        repeat (5) tick();
        check("stall_high_cycles", 32'(highCycles - h0), 4);
        check("stall_transfers", 32'(accepted - a0), 1);

        // Out-of-range points
        a0 = accepted;
        sendPoint(9'd320, 9'd0, 12'h123);
        sendPoint(9'd0, 9'd240, 12'h456);
        repeat (10) tick();
        check("oor_writes", 32'(accepted - a0), 0);
        check("oor_ovf", 32'(overflow), 0);
`ifdef DRAW_POINT_RECEIVER_STATS_EN
        check("oor_drops", 32'(dropCount), 2);
`endif

        // Burst of 20 while stalled: X=0..16 survive, 17..19 lost
        a0 = accepted;
        waitreq = 1'b1;
        for (int x = 0; x < 17; x++) begin
            sb.push_back('{addr: 17'(x), data: {4'h0, 12'(12'h100 + x)}});
        end
        for (int x = 0; x < 20; x++) begin
            posX   = 9'(x);
            posY   = 9'd0;
            rgb    = 12'(12'h100 + x);
            update = 1'b1;
            tick();
        end
        update = 1'b0;
        tick();
        check("burst_ovf", 32'(overflow), 1);
        check("burst_busy", 32'(busy), 1);
`ifdef DRAW_POINT_RECEIVER_STATS_EN
        check("burst_drops", 32'(dropCount), 5);
`endif
        waitreq = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        check("burst_drained", 32'(sb.size()), 0);
        repeat (3) tick();
        check("burst_transfers", 32'(accepted - a0), 17);
        check("burst_busy_end", 32'(busy), 0);

        // Reset mid-write with 5 points queued
        waitreq = 1'b1;
        for (int x = 0; x < 6; x++) begin
            sb.push_back('{addr: 17'(960 + x), data: {4'h0, 12'(12'h200 + x)}});
        end
        for (int x = 0; x < 6; x++) begin
            posX   = 9'(x);
            posY   = 9'd3;
            rgb    = 12'(12'h200 + x);
            update = 1'b1;
            tick();
        end
        update = 1'b0;
        tick();
        check("prerst_write", 32'(write), 1);
        check("prerst_busy", 32'(busy), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_write", 32'(write), 0);
        check("midrst_addr", 32'(address), 0);
        check("midrst_data", 32'(wdata), 0);
        check("midrst_ovf", 32'(overflow), 0);
        check("midrst_busy", 32'(busy), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        waitreq = 1'b0;
        a0 = accepted;
        h0 = highCycles;
        repeat (20) tick();
        check("postrst_writes", 32'(highCycles - h0), 0);
        check("postrst_xfers", 32'(accepted - a0), 0);
        check("postrst_busy", 32'(busy), 0);
        check("postrst_ovf", 32'(overflow), 0);
`ifdef DRAW_POINT_RECEIVER_STATS_EN
        check("postrst_drops", 32'(dropCount), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
